cv32e40p_x_result_arb: RTL and testbench
========================================

// Module: cv32e40p_x_result_arb
// PURPOSE
// - Arbitrates register-file write port B between core WB and X-interface result channel.
// - Buffers accepted X results in a DEPTH-entry FIFO.
// - Pulses the X-dispatcher scoreboard clear only when the result is actually written.
// - A starvation counter guarantees X results drain under continuous core WB traffic.
// - Sits between the X-interface and the register file, beside the X-interface dispatcher.
// PARAMETERS
// - DEPTH       2  X-result FIFO entries (>=1, power of 2)
// - STARVE_MAX  4  consecutive cycles FIFO head may lose to core before core is stalled (>=1)
// PORTS
// - clk_i             in   1   clock
// - rst_i             in   1   synchronous, active-high reset
// - x_result_valid_i  in   1   X result valid
// - x_result_ready_o  out  1   X result ready
// - x_result_id_i     in   4   X result instruction id
// - x_result_rd_i     in   5   X result destination register
// - x_result_we_i     in   1   X result write enable
// - x_result_data_i   in   32  X result data
// - core_we_i         in   1   core WB write request for port B
// - core_waddr_i      in   5   core WB address
// - core_wdata_i      in   32  core WB data
// - core_stall_o      out  1   core WB must hold; X head granted this cycle
// - rf_we_o           out  1   RF port B write enable
// - rf_waddr_o        out  5   RF port B address
// - rf_wdata_o        out  32  RF port B data
// - sb_clr_valid_o    out  1   pulse: clear scoreboard bit sb_clr_addr_o
// - sb_clr_addr_o     out  5   register whose pending X write completed
// - sb_clr_id_o       out  4   id of the completed X instruction
// - x_pending_o       out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
// Reset
// - Sync on rst_i: FIFO empty, starve counter 0.
// - x_result_ready_o=1, all other outputs 0.
// - Reset mid-operation discards buffered results with no sb_clr pulse; dispatcher reset covers this.
// Accept
// - x_result_ready_o = ~full. No pop-through while full: ready stays 0 even if head pops that cycle.
// - On valid&ready: push {id,rd,data} only if we=1 and rd!=0; otherwise consume and drop, no sb_clr.
// Arbitration (combinational outputs from registered FIFO head; min accept-to-write latency 1 cycle, no bypass)
// - FIFO empty: core wins; rf_* = core_* gated by core_we_i.
// - FIFO non-empty, core_we_i=0: head granted.
// - FIFO non-empty, core_we_i=1, starve<STARVE_MAX: core wins, starve++.
// - FIFO non-empty, core_we_i=1, starve==STARVE_MAX: head granted, core_stall_o=1; core holds its request.
// - Head grant: rf_we_o=1, rf_waddr_o=head.rd, rf_wdata_o=head.data; sb_clr_valid_o=1 with head rd/id in the same cycle; pop.
// - Starve counter: clears on head grant or FIFO empty; saturates at STARVE_MAX. Width $clog2(STARVE_MAX+1).
// Occupancy
// - Simultaneous push and pop: occupancy unchanged; pointers wrap modulo DEPTH.
// Ordering
// - FIFO preserves X result order.
// - The scoreboard guarantees core_waddr_i never equals any buffered rd; SVA checks this, no RTL handling.
// - core_stall_o never asserts when FIFO empty or core_we_i=0.
// STRUCTURE
// - typedef x_result_entry_t {id[3:0], rd[4:0], data[31:0]} goes in cv32e40p_core_v_xif_pkg.
// - Sub-module cv32e40p_x_result_fifo: generic sync FIFO, parameters DEPTH and entry type, with full/empty/count.
// - Arbiter, starve counter and output muxing stay in this module.
// - SVAs, guarded by ifndef SYNTHESIS:
//   - no push when full
//   - no pop when empty
//   - one-hot grant
//   - core/X address-disjointness
// TESTING
// - Idle, single X result {id=3,rd=5,we=1,data=0xDEADBEEF}, core_we=0 -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, sb_clr_valid=1 (addr=5, id=3).
// - X result we=0, or rd=0 -> accepted (ready=1), no rf write, no sb_clr, x_pending stays 0.
// - DEPTH=2: three back-to-back results with core_we=1 held -> ready drops after 2 accepts; third held until a pop.
// - core_we=1 continuously, one buffered X result, STARVE_MAX=4 -> core wins 4 cycles; cycle 5 core_stall_o=1 and X written; cycle 6 core wins, stall=0.
// - Push and pop same cycle at occupancy 1 -> occupancy stays 1, FIFO order preserved across pointer wrap (ids 0..7 written in order).
// - rst_i asserted with 2 buffered entries -> next cycle x_pending=0, ready=1, rf_we=0, no sb_clr pulses for dropped entries.

Source files
------------

// File: rtl/cv32e40p_core_v_xif_pkg.sv
`default_nettype none
//==============================================================================
// Package  : cv32e40p_core_v_xif_pkg
// Brief    : Shared types for the X-interface result path (result entry
//            layout, field widths, write-qualification helper).
// Revision : 1.0 - initial release
//==============================================================================
package cv32e40p_core_v_xif_pkg;

   localparam int unsigned X_ID_W   = 4;
   localparam int unsigned X_RD_W   = 5;
   localparam int unsigned X_DATA_W = 32;

   // One buffered X result waiting for register-file port B
   typedef struct packed {
      logic [X_ID_W-1:0]   id;
      logic [X_RD_W-1:0]   rd;
      logic [X_DATA_W-1:0] data;
   } x_result_entry_t;

   // A result only needs a register-file write when enabled and not targeting x0
   function automatic logic x_result_writes_rf(input logic we, input logic [X_RD_W-1:0] rd);
      return we && (rd != '0);
   endfunction

endpackage : cv32e40p_core_v_xif_pkg
`default_nettype wire

// File: rtl/cv32e40p_x_result_fifo.sv
`default_nettype none
//==============================================================================
// Module   : cv32e40p_x_result_fifo
// Brief    : Generic synchronous FIFO with registered head, occupancy count
//            and full/empty flags. Pointers wrap modulo DEPTH.
// Revision : 1.0 - initial release
//==============================================================================
module cv32e40p_x_result_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         entry_t = logic [31:0]
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  entry_t                     push_data_i,
   input  logic                       pop_i,
   output entry_t                     head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   // Advance a pointer, wrapping back to entry 0 after the last slot
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count == CNT_W'(DEPTH));
   assign empty_o = (count == '0);
   assign count_o = count;
   assign head_o  = mem[rd_ptr];

   // Storage array: written on push, no reset needed since reads are gated by empty
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem[wr_ptr] <= push_data_i;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_i) wr_ptr <= next_ptr(wr_ptr);
         if (pop_i)  rd_ptr <= next_ptr(rd_ptr);
         case ({push_i, pop_i})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule : cv32e40p_x_result_fifo
`default_nettype wire

// File: rtl/cv32e40p_x_result_arb.sv
`default_nettype none
//==============================================================================
// Module   : cv32e40p_x_result_arb
// Brief    : Arbitrates register-file write port B between core write-back
//            and buffered X-interface results. A starvation counter forces
//            the FIFO head through after STARVE_MAX consecutive core wins.
//            The scoreboard clear pulses only on the cycle the X result is
//            actually written.
// Revision : 1.0 - initial release
//==============================================================================
module cv32e40p_x_result_arb
   import cv32e40p_core_v_xif_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       x_result_valid_i,
   output logic                       x_result_ready_o,
   input  logic [3:0]                 x_result_id_i,
   input  logic [4:0]                 x_result_rd_i,
   input  logic                       x_result_we_i,
   input  logic [31:0]                x_result_data_i,
   input  logic                       core_we_i,
   input  logic [4:0]                 core_waddr_i,
   input  logic [31:0]                core_wdata_i,
   output logic                       core_stall_o,
   output logic                       rf_we_o,
   output logic [4:0]                 rf_waddr_o,
   output logic [31:0]                rf_wdata_o,
   output logic                       sb_clr_valid_o,
   output logic [4:0]                 sb_clr_addr_o,
   output logic [3:0]                 sb_clr_id_o,
   output logic [$clog2(DEPTH+1)-1:0] x_pending_o
);

   localparam int unsigned ST_W = $clog2(STARVE_MAX+1);

   x_result_entry_t  push_entry;
   x_result_entry_t  head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             grant_x;
   logic             grant_core;
   logic             starve_hit;
   logic [ST_W-1:0]  starve_cnt;

   // Accept whenever there is room; results that do not write the RF are consumed and dropped
   assign x_result_ready_o = ~fifo_full;
   assign push             = x_result_valid_i && x_result_ready_o &&
                             x_result_writes_rf(x_result_we_i, x_result_rd_i);

   assign push_entry.id   = x_result_id_i;
   assign push_entry.rd   = x_result_rd_i;
   assign push_entry.data = x_result_data_i;

   cv32e40p_x_result_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (x_result_entry_t)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (grant_x),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (x_pending_o)
   );

   // Head wins when the core is idle or has starved it long enough; never during reset
   assign starve_hit = (starve_cnt == ST_W'(STARVE_MAX));
   assign grant_x    = ~rst_i && ~fifo_empty && (~core_we_i || starve_hit);
   assign grant_core = core_we_i && ~grant_x;

   // Port B output mux and scoreboard clear, driven from the registered FIFO head
   always_comb begin
      rf_we_o        = 1'b0;
      rf_waddr_o     = '0;
      rf_wdata_o     = '0;
      sb_clr_valid_o = 1'b0;
      sb_clr_addr_o  = '0;
      sb_clr_id_o    = '0;
      core_stall_o   = grant_x && core_we_i;
      if (grant_x) begin
         rf_we_o        = 1'b1;
         rf_waddr_o     = head.rd;
         rf_wdata_o     = head.data;
         sb_clr_valid_o = 1'b1;
         sb_clr_addr_o  = head.rd;
         sb_clr_id_o    = head.id;
      end else if (grant_core) begin
         rf_we_o        = 1'b1;
         rf_waddr_o     = core_waddr_i;
         rf_wdata_o     = core_wdata_i;
      end
   end

   // Count consecutive core wins over a waiting head; cleared by a head grant or an empty FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (fifo_empty || grant_x) begin
         starve_cnt <= '0;
      end else if (core_we_i && !starve_hit) begin
         starve_cnt <= starve_cnt + ST_W'(1);
      end
   end

`ifndef SYNTHESIS
   // Number of buffered entries per destination register, for the disjointness check
   int unsigned pend_cnt [32];

   // Track buffered destinations alongside the FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) pend_cnt[i] <= 0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            pend_cnt[i] <= pend_cnt[i]
                         + 32'(push    && (x_result_rd_i == 5'(i)))
                         - 32'(grant_x && (head.rd       == 5'(i)));
         end
      end
   end

   a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));
   a_no_pop_empty : assert property (@(posedge clk_i) disable iff (rst_i) !(grant_x && fifo_empty));
   a_onehot_grant : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0({grant_x, grant_core}));
   a_addr_disjoint: assert property (@(posedge clk_i) disable iff (rst_i)
                                     core_we_i |-> (pend_cnt[core_waddr_i] == 0));
   a_stall_legal  : assert property (@(posedge clk_i) disable iff (rst_i)
                                     core_stall_o |-> (!fifo_empty && core_we_i));
`endif

endmodule : cv32e40p_x_result_arb
`default_nettype wire

// File: tb/tb_cv32e40p_x_result_arb.sv
`default_nettype none
//==============================================================================
// Module   : tb_cv32e40p_x_result_arb
// Brief    : Self-checking bench for cv32e40p_x_result_arb. A queue-based
//            reference model predicts every output each cycle; directed
//            scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
//==============================================================================
module tb_cv32e40p_x_result_arb;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        x_valid;
   logic        x_ready;
   logic [3:0]  x_id;
   logic [4:0]  x_rd;
   logic        x_we;
   logic [31:0] x_data;
   logic        core_we;
   logic [4:0]  core_waddr;
   logic [31:0] core_wdata;
   logic        core_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        sb_valid;
   logic [4:0]  sb_addr;
   logic [3:0]  sb_id;
   logic [1:0]  x_pending;

   typedef struct {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t q[$];
   int   starve;
   int   n_cmp;
   int   n_err;

   always #5 clk = ~clk;

   cv32e40p_x_result_arb #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .x_result_valid_i (x_valid),
      .x_result_ready_o (x_ready),
      .x_result_id_i    (x_id),
      .x_result_rd_i    (x_rd),
      .x_result_we_i    (x_we),
      .x_result_data_i  (x_data),
      .core_we_i        (core_we),
      .core_waddr_i     (core_waddr),
      .core_wdata_i     (core_wdata),
      .core_stall_o     (core_stall),
      .rf_we_o          (rf_we),
      .rf_waddr_o       (rf_waddr),
      .rf_wdata_o       (rf_wdata),
      .sb_clr_valid_o   (sb_valid),
      .sb_clr_addr_o    (sb_addr),
      .sb_clr_id_o      (sb_id),
      .x_pending_o      (x_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check all outputs against the model for the current inputs, then advance one clock
   task automatic do_cycle();
      int          occ;
      bit          xg;
      bit          rdy;
      bit          push_ok;
      ent_t        e;
      logic [4:0]  ea;
      logic [31:0] ed;
      #1;
      occ     = q.size();
      rdy     = (occ < DEPTH);
      xg      = !rst && (occ > 0) && (!core_we || starve == STARVE_MAX);
      push_ok = x_valid && rdy && x_we && (x_rd != 5'd0);
      e.id = x_id; e.rd = x_rd; e.data = x_data;
      if (xg)           begin ea = q[0].rd;    ed = q[0].data;  end
      else if (core_we) begin ea = core_waddr; ed = core_wdata; end
      else              begin ea = '0;         ed = '0;         end
      chk("ready",    32'(x_ready),    32'(rdy));
      chk("pending",  32'(x_pending),  32'(occ));
      chk("rf_we",    32'(rf_we),      32'(xg || core_we));
      chk("rf_waddr", 32'(rf_waddr),   32'(ea));
      chk("rf_wdata", rf_wdata,        ed);
      chk("stall",    32'(core_stall), 32'(xg && core_we));
      chk("sb_valid", 32'(sb_valid),   32'(xg));
      chk("sb_addr",  32'(sb_addr),    xg ? 32'(q[0].rd) : 32'd0);
      chk("sb_id",    32'(sb_id),      xg ? 32'(q[0].id) : 32'd0);
      @(posedge clk);
      if (rst) begin
         q.delete();
         starve = 0;
      end else begin
         if (xg) void'(q.pop_front());
         if (push_ok) q.push_back(e);
         if (occ == 0 || xg)                          starve = 0;
         else if (core_we && starve < STARVE_MAX)     starve++;
      end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      n_cmp = 0; n_err = 0; starve = 0;
      rst = 1'b1; x_valid = 0; x_id = 0; x_rd = 0; x_we = 0; x_data = 0;
      core_we = 0; core_waddr = 0; core_wdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_cycle();

      // Reset state
      rst = 1'b0;
      #1;
      chk("rst_ready",   32'(x_ready),   32'd1);
      chk("rst_rf_we",   32'(rf_we),     32'd0);
      chk("rst_pending", 32'(x_pending), 32'd0);
      chk("rst_sb",      32'(sb_valid),  32'd0);
      do_cycle();

      // Single X result, core idle: written one cycle after acceptance
      x_valid = 1; x_id = 4'd3; x_rd = 5'd5; x_we = 1; x_data = 32'hDEADBEEF;
      do_cycle();
      x_valid = 0;
      #1;
      chk("single_rf_we",   32'(rf_we),    32'd1);
      chk("single_waddr",   32'(rf_waddr), 32'd5);
      chk("single_wdata",   rf_wdata,      32'hDEADBEEF);
      chk("single_sb",      32'(sb_valid), 32'd1);
      chk("single_sb_addr", 32'(sb_addr),  32'd5);
      chk("single_sb_id",   32'(sb_id),    32'd3);
      do_cycle();

      // Results that do not write the RF are consumed and dropped
      x_valid = 1; x_id = 4'd1; x_rd = 5'd7; x_we = 0;
      #1;
      chk("drop_ready", 32'(x_ready), 32'd1);
      do_cycle();
      x_rd = 5'd0; x_we = 1;
      do_cycle();
      x_valid = 0;
      #1;
      chk("drop_pending", 32'(x_pending), 32'd0);
      chk("drop_rf_we",   32'(rf_we),     32'd0);
      chk("drop_sb",      32'(sb_valid),  32'd0);
      do_cycle();

      // Three back-to-back results while the core holds the port
      core_we = 1; core_waddr = 5'd20; core_wdata = 32'hC0DE0020;
      x_valid = 1; x_we = 1;
      for (int i = 0; i < 2; i++) begin
         x_id = 4'(i); x_rd = 5'(i + 1); x_data = $urandom;
         do_cycle();
      end
      x_id = 4'd2; x_rd = 5'd3; x_data = $urandom;
      #1;
      chk("full_ready", 32'(x_ready), 32'd0);
      waited = 0;
      while (!x_ready && waited < 20) begin
         do_cycle();
         waited++;
      end
      chk("third_held_cycles", 32'(waited), 32'd4);
      do_cycle();
      x_valid = 0; core_we = 0;
      repeat (4) do_cycle();

      // Starvation: core wins STARVE_MAX cycles, then the head is forced through
      core_we = 1; core_waddr = 5'd21; core_wdata = 32'hC0DE0021;
      x_valid = 1; x_id = 4'd9; x_rd = 5'd6; x_data = 32'h12345678;
      do_cycle();
      x_valid = 0;
      for (int i = 0; i < STARVE_MAX; i++) begin
         #1;
         chk("starve_core_stall", 32'(core_stall), 32'd0);
         chk("starve_core_addr",  32'(rf_waddr),   32'd21);
         do_cycle();
      end
      #1;
      chk("starve_hit_stall", 32'(core_stall), 32'd1);
      chk("starve_hit_addr",  32'(rf_waddr),   32'd6);
      chk("starve_hit_sb",    32'(sb_valid),   32'd1);
      do_cycle();
      #1;
      chk("starve_after_stall", 32'(core_stall), 32'd0);
      chk("starve_after_addr",  32'(rf_waddr),   32'd21);
      do_cycle();
      core_we = 0;

      // Push and pop in the same cycle at occupancy 1, order kept across wraps
      x_valid = 1; x_we = 1; x_id = 4'd0; x_rd = 5'd1; x_data = 32'h100;
      do_cycle();
      for (int i = 1; i < 8; i++) begin
         x_id = 4'(i); x_rd = 5'(i + 1); x_data = 32'h100 + 32'(i);
         #1;
         chk("wrap_sb_id",   32'(sb_id),     32'(i - 1));
         chk("wrap_pending", 32'(x_pending), 32'd1);
         do_cycle();
      end
      x_valid = 0;
      #1;
      chk("wrap_last_id", 32'(sb_id), 32'd7);
      do_cycle();

      // Reset with two buffered entries drops them silently
      core_we = 1; core_waddr = 5'd22; core_wdata = 32'hC0DE0022;
      x_valid = 1; x_id = 4'd4; x_rd = 5'd9; x_data = 32'hAAAA0001;
      do_cycle();
      x_id = 4'd5; x_rd = 5'd10; x_data = 32'hAAAA0002;
      do_cycle();
      x_valid = 0;
      #1;
      chk("prerst_pending", 32'(x_pending), 32'd2);
      rst = 1;
      do_cycle();
      rst = 0; core_we = 0;
      #1;
      chk("postrst_pending", 32'(x_pending), 32'd0);
      chk("postrst_ready",   32'(x_ready),   32'd1);
      chk("postrst_rf_we",   32'(rf_we),     32'd0);
      chk("postrst_sb",      32'(sb_valid),  32'd0);
      do_cycle();

      // Randomized traffic; X destinations and core destinations kept disjoint
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 99) == 0);
         x_valid    = $urandom_range(0, 1) == 1;
         x_we       = $urandom_range(0, 7) != 0;
         x_rd       = 5'($urandom_range(0, 15));
         x_id       = 4'($urandom);
         x_data     = $urandom;
         core_we    = $urandom_range(0, 3) != 0;
         core_waddr = 5'(16 + $urandom_range(0, 15));
         core_wdata = $urandom;
         do_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_cv32e40p_x_result_arb
`default_nettype wire
